// File: rtl/data_memory_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, error causes,
// latency limits and small helpers used by the core and its statistics block.
package dm_responder_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_BOTH  = 2'd1;
    localparam logic [1:0] ERR_ALIGN = 2'd2;
    localparam logic [1:0] ERR_RANGE = 2'd3;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dm_req_t;

    // First matching cause wins; out-of-range addresses never alias into the array.
    function automatic logic [1:0] classify_req(input logic        rd,
                                                input logic        wr,
                                                input logic [31:0] addr,
                                                input logic [31:0] limit);
        logic [1:0] cause;
        cause = ERR_NONE;
        if (rd && wr)
            cause = ERR_BOTH;
        else if (addr[1:0] != 2'b00)
            cause = ERR_ALIGN;
        else if (addr >= limit)
            cause = ERR_RANGE;
        return cause;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// MEM-stage load/store bus between the CPU (master) and the data-memory responder (slave).
interface data_memory_responder_if;

    logic        Req;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic [31:0] Read_data;
    logic        Ready;
    logic        Busy;
    logic        Error;

    modport master (
        output Req, MemRead, MemWrite, Address, Write_data,
        input  Read_data, Ready, Busy, Error
    );

    modport slave (
        input  Req, MemRead, MemWrite, Address, Write_data,
        output Read_data, Ready, Busy, Error
    );

endinterface

// File: rtl/data_memory_responder_wait_counter.sv
// Loadable 4-bit down-counter with enable and zero flag; times the WAIT phase.
module dm_wait_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic       zero
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    // NOTE: defaulting count_d before any branch keeps this block free of inferred latches.
    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (en && (count_q != 4'd0))
            count_d = count_q - 4'd1;
    end

    // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n)
            count_q <= 4'd0;
        else
            count_q <= count_d;
    end

    assign zero = (count_q == 4'd0);

endmodule

// File: rtl/data_memory_responder.sv
// Multi-cycle data-memory responder with programmable wait states.
// Optional transaction counters are enabled by defining DM_RESPONDER_STATS_EN.
module data_memory_responder
    import dm_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic                    CLK,
    input  logic                    RST,
    data_memory_responder_if.slave  bus
`ifdef DM_RESPONDER_STATS_EN
    ,
    output logic [15:0]             Read_count,
    output logic [15:0]             Write_count,
    output logic [15:0]             Error_count
`endif
);

    localparam int          IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD  = 4'(LATENCY - 1);

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("data_memory_responder: LATENCY must be within 1..15");
    end
    if (DEPTH_WORDS < 4 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("data_memory_responder: DEPTH_WORDS must be a power of two, at least 4");
    end

    logic [1:0]       state_q, state_d;
    dm_req_t          req_q, req_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [31:0]      mem_q [DEPTH_WORDS];

    logic             cnt_load;
    logic             cnt_en;
    logic             cnt_zero;
    logic             access;
    logic [1:0]       err_cause;
    logic [IDX_W-1:0] mem_idx;
    logic             mem_we;

    dm_wait_counter u_wait_counter (
        .clk      (CLK),
        .rst_n    (RST),
        .load     (cnt_load),
        .load_val (WAIT_LOAD),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    // The latched request is stable from acceptance through RESP, so the cause is too.
    assign err_cause = classify_req(req_q.rd, req_q.wr, req_q.addr, ADDR_LIMIT);
    assign mem_idx   = req_q.addr[IDX_W+1:2];
    assign mem_we    = access && req_q.wr && (err_cause == ERR_NONE);

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        rdata_d  = rdata_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        access   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Req && (bus.MemRead || bus.MemWrite)) begin
                    req_d    = '{rd: bus.MemRead, wr: bus.MemWrite,
                                 addr: bus.Address, wdata: bus.Write_data};
                    cnt_load = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (cnt_zero) begin
                    access  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (access && req_q.rd && (err_cause == ERR_NONE))
            rdata_d = mem_q[mem_idx];
    end

    // NOTE: the array sits in flops with a synchronous clear because reset must zero every word.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            req_q   <= '0;
            rdata_q <= '0;
            for (int i = 0; i < DEPTH_WORDS; i++)
                mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            if (mem_we)
                mem_q[mem_idx] <= req_q.wdata;
        end
    end

    assign bus.Read_data = rdata_q;
    assign bus.Busy      = (state_q != IDLE);
    assign bus.Ready     = (state_q == RESP);
    assign bus.Error     = (state_q == RESP) && (err_cause != ERR_NONE);

`ifdef DM_RESPONDER_STATS_EN
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    // Counted on the completing edge; an errored request only bumps the error count.
    always_comb begin
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        err_cnt_d = err_cnt_q;
        if (access) begin
            if (err_cause != ERR_NONE)
                err_cnt_d = sat_inc16(err_cnt_q);
            else if (req_q.wr)
                wr_cnt_d = sat_inc16(wr_cnt_q);
            else
                rd_cnt_d = sat_inc16(rd_cnt_q);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign Read_count  = rd_cnt_q;
    assign Write_count = wr_cnt_q;
    assign Error_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: directed cases plus randomized
// transactions scored against a transaction-level memory model.
module tb_data_memory_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 3;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    data_memory_responder_if bus();

`ifdef DM_RESPONDER_STATS_EN
    logic [15:0] read_count, write_count, error_count;
`endif

    data_memory_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
`ifdef DM_RESPONDER_STATS_EN
        ,
        .Read_count  (read_count),
        .Write_count (write_count),
        .Error_count (error_count)
`endif
    );

    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_rdata;
    int          m_rd_cnt, m_wr_cnt, m_err_cnt;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic is_illegal(input logic rd, input logic wr, input logic [31:0] addr);
        return (rd && wr) || (addr % 4 != 0) || (addr >= 32'(4 * DEPTH));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++)
            model_mem[i] = '0;
        model_rdata = '0;
        m_rd_cnt    = 0;
        m_wr_cnt    = 0;
        m_err_cnt   = 0;
    endtask

    task automatic idle_inputs();
        bus.Req        = 1'b0;
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.Address    = '0;
        bus.Write_data = '0;
    endtask

    task automatic check_stats(input string tag);
`ifdef DM_RESPONDER_STATS_EN
        check({tag, "_read_count"},  read_count,  m_rd_cnt);
        check({tag, "_write_count"}, write_count, m_wr_cnt);
        check({tag, "_error_count"}, error_count, m_err_cnt);
`endif
    endtask

    // One full access: present for one cycle, scramble inputs while busy, score the response.
    task automatic transact(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata);
        logic exp_err;
        int   k;
        bit   seen;
        exp_err = is_illegal(rd, wr, addr);
        @(negedge CLK);
        bus.Req = 1'b1; bus.MemRead = rd; bus.MemWrite = wr;
        bus.Address = addr; bus.Write_data = wdata;
        @(negedge CLK);
        k = 1;
        seen = 0;
        while (!seen && k <= 40) begin
            if (bus.Ready) begin
                seen = 1;
            end else begin
                check("busy_in_wait", bus.Busy, 1'b1);
                check("error_early", bus.Error, 1'b0);
                bus.Req = 1'($urandom); bus.MemRead = 1'($urandom); bus.MemWrite = 1'($urandom);
                bus.Address = $urandom; bus.Write_data = $urandom;
                @(negedge CLK);
                k++;
            end
        end
        idle_inputs();
        if (!seen) begin
            check("ready_timeout", k, LAT + 1);
            return;
        end
        if (exp_err) begin
            m_err_cnt++;
        end else if (wr) begin
            model_mem[addr / 4] = wdata;
            m_wr_cnt++;
        end else begin
            model_rdata = model_mem[addr / 4];
            m_rd_cnt++;
        end
        check("latency", k, LAT + 1);
        check("busy_at_ready", bus.Busy, 1'b1);
        check("error", bus.Error, exp_err);
        check("read_data", bus.Read_data, model_rdata);
        @(negedge CLK);
        check("ready_pulse", bus.Ready, 1'b0);
        check("busy_release", bus.Busy, 1'b0);
    endtask

    // Req held high for three reads; acceptance is only possible from IDLE.
    task automatic back_to_back();
        int   rises[$];
        int   idx;
        logic prev_busy;
        idx = 0;
        prev_busy = 1'b0;
        @(negedge CLK);
        bus.Req = 1'b1; bus.MemRead = 1'b1; bus.MemWrite = 1'b0; bus.Address = 32'h0;
        for (int cyc = 0; cyc < 100 && idx < 3; cyc++) begin
            @(negedge CLK);
            if (bus.Busy && !prev_busy)
                rises.push_back(cyc);
            prev_busy = bus.Busy;
            if (bus.Ready) begin
                model_rdata = model_mem[idx];
                m_rd_cnt++;
                check("b2b_read_data", bus.Read_data, model_rdata);
                check("b2b_error", bus.Error, 1'b0);
                idx++;
                bus.Address = 32'(idx * 4);
                if (idx == 3)
                    bus.Req = 1'b0;
            end
        end
        idle_inputs();
        check("b2b_completions", idx, 3);
        check("b2b_accepts", rises.size(), 3);
        // Busy window is LAT+1 cycles, followed by the single IDLE cycle that accepts.
        if (rises.size() == 3) begin
            check("b2b_spacing_0", rises[1] - rises[0], LAT + 2);
            check("b2b_spacing_1", rises[2] - rises[1], LAT + 2);
        end
    endtask

    initial begin
        logic [31:0] addr;
        int          kind;
        int          op;
        idle_inputs();
        model_clear();

        repeat (2) @(negedge CLK);
        check("reset_busy", bus.Busy, 1'b0);
        check("reset_ready", bus.Ready, 1'b0);
        check("reset_error", bus.Error, 1'b0);
        check("reset_read_data", bus.Read_data, 32'h0);
        RST = 1'b1;

        transact(1'b1, 1'b0, 32'h00, 32'h0);
        transact(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        transact(1'b1, 1'b0, 32'h10, 32'h0);
        transact(1'b1, 1'b0, 32'h12, 32'h0);
        transact(1'b1, 1'b0, 32'h400, 32'h0);
        transact(1'b1, 1'b0, 32'h10, 32'h0);
        transact(1'b1, 1'b1, 32'h20, 32'h12345678);
        transact(1'b1, 1'b0, 32'h20, 32'h0);
        transact(1'b1, 1'b0, 32'h10, 32'h0);
        check_stats("directed");

        @(negedge CLK);
        bus.Req = 1'b1; bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.Address = 32'h44;
        @(negedge CLK);
        check("ignored_req_busy", bus.Busy, 1'b0);
        idle_inputs();

        @(negedge CLK);
        bus.Req = 1'b1; bus.MemWrite = 1'b1; bus.Address = 32'h30; bus.Write_data = 32'hCAFEF00D;
        @(negedge CLK);
        idle_inputs();
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("abort_busy", bus.Busy, 1'b0);
        check("abort_ready", bus.Ready, 1'b0);
        check("abort_error", bus.Error, 1'b0);
        check("abort_read_data", bus.Read_data, 32'h0);
        RST = 1'b1;
        model_clear();
        check_stats("after_reset");

        back_to_back();
        check_stats("b2b");
        transact(1'b1, 1'b0, 32'h30, 32'h0);

        for (int t = 0; t < 120; t++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0)
                addr = ($urandom_range(0, DEPTH - 1) << 2) | $urandom_range(1, 3);
            else if (kind == 1)
                addr = 32'(4 * DEPTH) + ($urandom_range(0, 4095) << 2);
            else if (kind == 2)
                addr = $urandom | 32'h8000_0000;
            else if (kind < 7)
                addr = $urandom_range(0, 15) << 2;
            else
                addr = $urandom_range(0, DEPTH - 1) << 2;
            op = $urandom_range(0, 9);
            transact(op == 0 || op >= 5, op <= 4, addr, $urandom);
        end
        check_stats("random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
